// File: rtl/br_pkg.sv
// Shared types and constants for the branch-resolution slice.
package br_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } resolve_state_t;

    localparam logic BR_TAKEN  = 1'b1;
    localparam logic BR_NTAKEN = 1'b0;

endpackage

// File: rtl/br_fifo.sv
// 1-bit-wide FIFO with wrap-around pointers and an occupancy count.
module br_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic pop_i,
    input  logic clear_i,
    input  logic din_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic [DEPTH-1:0] mem_q;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];
    assign push_ok = push_i && !full_o && !clear_i;
    assign pop_ok  = pop_i && !empty_o && !clear_i;

    // NOTE: storage is not reset; the count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/br_resolve.sv
// Matches queued branch predictions against execute outcomes and drives recovery.
// Define BR_RESOLVE_STATS_EN to build the saturating br_cnt/miss_cnt counters.
module br_resolve
    import br_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int RECOV = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_vld,
    input  logic             pred_take,
    output logic             pred_rdy,
    input  logic             res_vld,
    input  logic             res_taken,
    output logic             upd_vld,
    output logic             taken,
    output logic             mispredict,
    output logic             flush,
    output logic             err,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int RW = (RECOV > 1) ? $clog2(RECOV) : 1;

    resolve_state_t state_q;
    logic [RW-1:0]  rcnt_q;
    logic           upd_vld_q, taken_q, mispredict_q, err_q;
    logic           full, empty, head;
    logic           in_run, pop, mismatch, push;

    assign in_run   = (state_q == RUN);
    assign pred_rdy = in_run && !full;
    assign pop      = res_vld && in_run && !empty;
    assign mismatch = pop && (head != res_taken);
    // Entries younger than a mispredicted branch are wrong-path, so a same-cycle push dies too.
    assign push     = pred_vld && pred_rdy && !mismatch;

    br_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (mismatch),
        .din_i   (pred_take),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            rcnt_q       <= '0;
            upd_vld_q    <= 1'b0;
            taken_q      <= BR_NTAKEN;
            mispredict_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            upd_vld_q    <= pop;
            mispredict_q <= mismatch;
            if (pop) taken_q <= res_taken;
            if (res_vld && in_run && empty) err_q <= 1'b1;
            case (state_q)
                RUN: begin
                    if (mismatch) begin
                        state_q <= RECOVER;
                        rcnt_q  <= RW'(RECOV - 1);
                    end
                end
                RECOVER: begin
                    if (rcnt_q == '0) state_q <= RUN;
                    else              rcnt_q  <= rcnt_q - 1'b1;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign upd_vld    = upd_vld_q;
    assign taken      = taken_q;
    assign mispredict = mispredict_q;
    assign err        = err_q;
    assign flush      = (state_q == RECOVER);

`ifdef BR_RESOLVE_STATS_EN
    logic [CNT_W-1:0] br_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (pop && (br_cnt_q != '1))        br_cnt_q   <= br_cnt_q + 1'b1;
            if (mismatch && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 1'b1;
        end
    end

    assign br_cnt   = br_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign br_cnt   = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: doc/br_resolve.md
# br_resolve

- Downstream consumer of the 2-bit branch predictor.
- Holds a small in-order queue of outstanding predictions (`pred_take`), matches each against the resolved outcome from execute, and detects mispredicts.
- Drives a registered `taken`/`upd_vld` update back into the predictor.
- Drives a flush/recovery window to the fetch stage and keeps optional accuracy statistics.

## Interface
Parameters:
- `DEPTH`, 4: outstanding-prediction queue entries; power of 2, ≥2.
- `RECOV`, 2: cycles `flush` stays high after a mispredict; ≥1.
- `CNT_W`, 16: width of statistics counters.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `pred_vld`  in  1  a prediction is issued this cycle.
- `pred_take`  in  1  predicted direction (1 = taken).
- `pred_rdy`  out  1  queue can accept a prediction.
- `res_vld`  in  1  oldest outstanding branch resolved this cycle.
- `res_taken`  in  1  actual direction.
- `upd_vld`  out  1  registered pulse: predictor update valid.
- `taken`  out  1  registered actual direction for the predictor.
- `mispredict`  out  1  registered one-cycle pulse on direction mismatch.
- `flush`  out  1  high for the whole recovery window.
- `err`  out  1  sticky: resolution arrived with an empty queue.
- `br_cnt`  out  `CNT_W`  resolved branches, saturating.
- `miss_cnt`  out  `CNT_W`  mispredicts, saturating.

## Operation
- Queue is a FIFO with wrap-around pointers and a count.
  - Push when `pred_vld && pred_rdy`.
  - Pop when `res_vld` and the queue is non-empty.
- `pred_rdy = (state == RUN) && !full`, combinational from registered state. A push while `pred_rdy` is low is dropped; no error is flagged.
- Push and pop in the same cycle: count is unchanged. This is legal when full only if `pred_rdy` was high, so in practice it occurs only when not full.
- On pop, compare the head entry with `res_taken`:
  - Next cycle: `upd_vld = 1`, `taken = res_taken`.
  - On mismatch, next cycle: `mispredict = 1`, whole queue cleared (younger entries are wrong-path), FSM enters RECOVER.
  - A push in the same cycle as a mismatching pop is discarded.
- `res_vld` with an empty queue:
  - No pop, no update.
  - `err` is set and stays set until reset.
- FSM states:
  - RUN → RECOVER on mismatch. Load the recovery counter with `RECOV - 1`.
  - RECOVER → RUN when the counter reaches 0; otherwise decrement.
  - In RECOVER: `flush = 1`, `pred_rdy = 0`, `res_vld` ignored (no pop, no update, no `err`).
- Statistics, when compiled in:
  - `br_cnt` +1 per pop.
  - `miss_cnt` +1 per mismatching pop.
  - Both saturate at all-ones and never wrap.
- Reset mid-operation: the queue is emptied immediately and the FSM returns to RUN. Outstanding entries are lost.

## Timing
- Reset values:
  - FSM = RUN, queue empty, so `pred_rdy` = 1.
  - `upd_vld`, `taken`, `mispredict`, `flush`, `err` = 0.
  - Counters = 0.
- Pop in cycle N:
  - `upd_vld`, `taken`, `mispredict` valid in cycle N+1.
  - `flush` high in cycles N+1 … N+`RECOV`.
  - `pred_rdy` returns high in cycle N+`RECOV`+1.
- Push in cycle N: the entry is visible at the head for a pop in cycle N+1 at the earliest.
- `err` rises in the cycle after the offending `res_vld`.
- Counter updates appear in the cycle after the pop.

## Configuration
- `BR_RESOLVE_STATS_EN` defined: `br_cnt`/`miss_cnt` registers and saturation logic are present.
- Not defined: no counter registers; both ports are driven constant 0. All other behaviour is identical.

## Structure
- Shared package `br_pkg`:
  - `resolve_state_t` enum {RUN, RECOVER}.
  - Direction constants `BR_TAKEN` = 1'b1, `BR_NTAKEN` = 1'b0.
- Sub-module `br_fifo`:
  - Generic 1-bit-wide FIFO, parameter `DEPTH`.
  - Ports: push, pop, clear, `full`, `empty`, head data.
  - `br_resolve` instantiates it once and owns the FSM, compare and counters.

## Test plan
- Reset, then push 1,0,1; resolve 1,0,1 in three consecutive cycles.
  - Three `upd_vld` pulses with `taken` = 1,0,1.
  - `mispredict` never high; `br_cnt` = 3, `miss_cnt` = 0.
- Fill with `DEPTH` = 4 pushes.
  - `pred_rdy` = 0 and a 5th push is dropped.
  - One pop raises `pred_rdy` the next cycle.
- Queue holds 1,1,1; resolve 0 at cycle N.
  - `mispredict` pulse at N+1; `flush` high at N+1..N+2.
  - Queue empty; `pred_rdy` = 1 at N+3; `miss_cnt` = 1.
- During RECOVER, drive `res_vld` = 1 and `pred_vld` = 1: no pop, no push, no `err`.
- `res_vld` on an empty queue: `err` = 1 next cycle and stays 1 across later traffic until `rst`.
- With `BR_RESOLVE_STATS_EN` and `CNT_W` = 2, resolve 5 mispredicts: `miss_cnt` saturates at 3.
